// File: rtl/dnn_dot_accel.sv
// Dot-product accelerator: one neuron, sum(w[i]*a[i]) in signed fixed point
// with optional ReLU and optional write-back of the result to memory.
//
// state | meaning
// IDLE  | waiting for a CTRL write
// RD_W  | weight read request presented, held through waitrequest
// WT_W  | waiting for weight readdatavalid
// RD_A  | activation read request presented, held through waitrequest
// WT_A  | waiting for activation readdatavalid
// MAC   | accumulate one product, advance index
// WB    | result write presented, held through waitrequest
// DONE  | publish RESULT, clear busy
module dnn_dot_accel #(
  parameter int FRAC_BITS = 16,
  parameter int LEN_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  output logic [31:0] master_address,
  output logic        master_read,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest,
  input  logic        master_readdatavalid
);

  typedef enum logic [2:0] {IDLE, RD_W, WT_W, RD_A, WT_A, MAC, WB, DONE} state_t;

  state_t           state;
  logic [31:0]      waddr;
  logic [31:0]      aaddr;
  logic [31:0]      oaddr;
  logic [LEN_W-1:0] len;
  logic             relu_en;
  logic             wb_en;
  logic [31:0]      result;
  logic             busy;
  logic [31:0]      acc;
  logic [LEN_W-1:0] idx;
  logic [31:0]      w_reg;
  logic [31:0]      a_reg;

  logic signed [63:0] prod;
  logic signed [63:0] prod_shift;
  logic [31:0]        acc_next;
  logic [31:0]        res_cur;
  logic [31:0]        res_next;
  logic [LEN_W-1:0]   idx_next;
  logic               unused_prod;

  // Fixed-point product: keep the 32 bits that sit above the fractional part.
  assign prod        = 64'($signed(w_reg)) * 64'($signed(a_reg));
  assign prod_shift  = prod >>> FRAC_BITS;
  assign unused_prod = ^prod_shift[63:32];
  assign acc_next    = acc + prod_shift[31:0];
  assign idx_next    = idx + LEN_W'(1);
  assign res_cur     = (relu_en && acc[31]) ? 32'h0 : acc;
  assign res_next    = (relu_en && acc_next[31]) ? 32'h0 : acc_next;

  // Register file writes plus the sequencing FSM; master outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      waddr            <= '0;
      aaddr            <= '0;
      oaddr            <= '0;
      len              <= '0;
      relu_en          <= 1'b0;
      wb_en            <= 1'b0;
      result           <= '0;
      busy             <= 1'b0;
      acc              <= '0;
      idx              <= '0;
      w_reg            <= '0;
      a_reg            <= '0;
      master_address   <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_writedata <= '0;
    end else begin
      if (slave_write && !busy) begin
        case (slave_address)
          3'd2: waddr <= slave_writedata;
          3'd3: aaddr <= slave_writedata;
          3'd4: len   <= slave_writedata[LEN_W-1:0];
          3'd6: oaddr <= slave_writedata;
          3'd7: begin
            relu_en <= slave_writedata[0];
            wb_en   <= slave_writedata[1];
          end
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (slave_write && slave_address == 3'd0) begin
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b1;
            if (len == '0) begin
              if (wb_en) begin
                state            <= WB;
                master_write     <= 1'b1;
                master_address   <= oaddr;
                master_writedata <= 32'h0;
              end else begin
                state <= DONE;
              end
            end else begin
              state          <= RD_W;
              master_read    <= 1'b1;
              master_address <= waddr;
            end
          end
        end
        RD_W: begin
          if (!master_waitrequest) begin
            master_read <= 1'b0;
            state       <= WT_W;
          end
        end
        WT_W: begin
          if (master_readdatavalid) begin
            w_reg          <= master_readdata;
            master_read    <= 1'b1;
            master_address <= aaddr + (32'(idx) << 2);
            state          <= RD_A;
          end
        end
        RD_A: begin
          if (!master_waitrequest) begin
            master_read <= 1'b0;
            state       <= WT_A;
          end
        end
        WT_A: begin
          if (master_readdatavalid) begin
            a_reg <= master_readdata;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          idx <= idx_next;
          if (idx_next == len) begin
            if (wb_en) begin
              state            <= WB;
              master_write     <= 1'b1;
              master_address   <= oaddr;
              master_writedata <= res_next;
            end else begin
              state <= DONE;
            end
          end else begin
            state          <= RD_W;
            master_read    <= 1'b1;
            master_address <= waddr + (32'(idx_next) << 2);
          end
        end
        WB: begin
          if (!master_waitrequest) begin
            master_write <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          result <= res_cur;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port; a same-cycle write is not visible until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slave_readdata <= '0;
    end else if (slave_read) begin
      case (slave_address)
        3'd0:    slave_readdata <= {31'b0, busy};
        3'd2:    slave_readdata <= waddr;
        3'd3:    slave_readdata <= aaddr;
        3'd4:    slave_readdata <= 32'(len);
        3'd5:    slave_readdata <= result;
        3'd6:    slave_readdata <= oaddr;
        3'd7:    slave_readdata <= {30'b0, wb_en, relu_en};
        default: slave_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_dot_accel.sv
// Directed bench for dnn_dot_accel with an SDRAM responder model and a
// transfer scoreboard.
module tb_dnn_dot_accel;
  localparam int FRAC = 16;

  logic        clk;
  logic        rst_n;
  logic [2:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic [31:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata;
  logic        master_waitrequest;
  logic        master_readdatavalid;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       obs_q[$];
  int          obs_rd    = 0;
  int          total     = 0;
  int          bad       = 0;
  int          viol_cnt  = 0;
  int          stall_n   = 0;
  int          dly_min   = 0;
  int          dly_max   = 0;
  int          stray_req = 0;
  bit          spur_en   = 1'b0;
  logic [31:0] mem [bit [31:0]];
  logic [31:0] wv [0:15];
  logic [31:0] av [0:15];
  logic [31:0] exp_res;

  dnn_dot_accel #(.FRAC_BITS(16), .LEN_W(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_readdata      (master_readdata),
    .master_waitrequest   (master_waitrequest),
    .master_readdatavalid (master_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // SDRAM responder: stalls, delayed read data, optional spurious valids.
  initial begin : responder
    bit          in_req, accepting, rv_pending, outstanding;
    logic        lat_rd, lat_wr;
    logic [31:0] lat_addr, lat_data, rv_data;
    int          remaining, rv_cnt, stray_done;
    xfer_t       o;
    in_req = 0; accepting = 0; rv_pending = 0; outstanding = 0;
    lat_rd = 0; lat_wr = 0; lat_addr = 0; lat_data = 0; rv_data = 0;
    remaining = 0; rv_cnt = 0; stray_done = 0;
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      master_readdatavalid = 1'b0;
      if (!rst_n) begin
        in_req = 0; accepting = 0; rv_pending = 0; outstanding = 0;
        master_waitrequest = 1'b0;
        continue;
      end
      if (accepting) begin
        accepting = 0;
        in_req = 0;
        o.wr = lat_wr;
        o.addr = lat_addr;
        o.data = lat_wr ? lat_data : 32'h0;
        obs_q.push_back(o);
        if (lat_rd) begin
          outstanding = 1;
          rv_pending = 1;
          rv_cnt = $urandom_range(dly_max, dly_min);
          rv_data = mem.exists(lat_addr) ? mem[lat_addr] : 32'hDEAD_BEEF;
        end
      end
      if (!in_req) begin
        if (master_read || master_write) begin
          if (outstanding || (master_read && master_write)) viol_cnt++;
          in_req = 1;
          lat_rd = master_read;
          lat_wr = master_write;
          lat_addr = master_address;
          lat_data = master_writedata;
          remaining = stall_n;
        end
      end else begin
        if (master_read !== lat_rd || master_write !== lat_wr ||
            master_address !== lat_addr ||
            (lat_wr && master_writedata !== lat_data)) viol_cnt++;
      end
      if (in_req) begin
        if (remaining > 0) begin
          master_waitrequest = 1'b1;
          remaining--;
        end else begin
          master_waitrequest = 1'b0;
          accepting = 1;
        end
      end else begin
        master_waitrequest = 1'b0;
      end
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = rv_data;
          rv_pending = 0;
          outstanding = 0;
        end else begin
          rv_cnt--;
        end
      end else if (stray_done != stray_req) begin
        master_readdatavalid = 1'b1;
        master_readdata = 32'h7FFF_0000;
        stray_done = stray_req;
      end else if (spur_en && !outstanding && $urandom_range(3, 0) == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata = $urandom;
      end
    end
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    @(posedge clk);
    #1;
    slave_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read = 1'b1;
    @(posedge clk);
    #1;
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic reg_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
    slave_address = a;
    slave_writedata = wd;
    slave_write = 1'b1;
    slave_read = 1'b1;
    @(posedge clk);
    #1;
    slave_write = 1'b0;
    slave_read = 1'b0;
    rd = slave_readdata;
  endtask

  // Loads memory, programs registers and pushes the expected transfers/result.
  task automatic setup_run(input logic [31:0] wa, input logic [31:0] aa, input logic [31:0] oa,
                           input int n, input logic [1:0] cfg);
    xfer_t       x;
    logic [31:0] acc;
    longint      p;
    acc = 32'h0;
    for (int i = 0; i < n; i++) begin
      mem[wa + 32'(4 * i)] = wv[i];
      mem[aa + 32'(4 * i)] = av[i];
      x.wr = 1'b0;
      x.data = 32'h0;
      x.addr = wa + 32'(4 * i);
      exp_q.push_back(x);
      x.addr = aa + 32'(4 * i);
      exp_q.push_back(x);
      p = longint'($signed(wv[i])) * longint'($signed(av[i]));
      acc = acc + 32'(p >>> FRAC);
    end
    exp_res = (cfg[0] && acc[31]) ? 32'h0 : acc;
    if (cfg[1]) begin
      x.wr = 1'b1;
      x.addr = oa;
      x.data = exp_res;
      exp_q.push_back(x);
    end
    reg_write(3'd2, wa);
    reg_write(3'd3, aa);
    reg_write(3'd4, 32'(n));
    reg_write(3'd6, oa);
    reg_write(3'd7, {30'b0, cfg});
  endtask

  // Waits for busy to drop, then scores RESULT and every master transfer.
  task automatic finish_run(input string tag, input int budget);
    logic [31:0] d;
    int          n;
    xfer_t       x;
    d = 32'h1;
    n = 0;
    while (d[0] === 1'b1 && n < budget) begin
      reg_read(3'd0, d);
      n++;
    end
    check({tag, "_done"}, d, 32'h0);
    reg_read(3'd5, d);
    check({tag, "_result"}, d, exp_res);
    check({tag, "_xfer_count"}, obs_q.size() - obs_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        check({tag, "_xfer"}, obs_q[obs_rd], x);
        obs_rd++;
      end
    end
    obs_rd = obs_q.size();
    check({tag, "_protocol"}, viol_cnt, 0);
  endtask

  task automatic basic_data();
    wv[0] = 32'h0001_0000; wv[1] = 32'h0002_0000; wv[2] = 32'hFFFF_8000;
    av[0] = 32'h0003_0000; av[1] = 32'h0000_8000; av[2] = 32'h0004_0000;
  endtask

  initial begin : main
    logic [31:0] d;
    logic [31:0] prev_res;
    int          cnt;
    bit          seen;
    rst_n = 1'b0;
    slave_address = 3'd0;
    slave_read = 1'b0;
    slave_write = 1'b0;
    slave_writedata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_master_read", master_read, 1'b0);
    check("rst_master_write", master_write, 1'b0);
    check("rst_master_address", master_address, 32'h0);
    check("rst_master_writedata", master_writedata, 32'h0);
    check("rst_readdata", slave_readdata, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      reg_read(3'(k), d);
      check($sformatf("rst_reg%0d", k), d, 32'h0);
    end

    // reserved address and read-during-write ordering
    reg_write(3'd1, 32'hFFFF_FFFF);
    reg_read(3'd1, d);
    check("reserved_reads_zero", d, 32'h0);
    reg_write(3'd2, 32'hAAAA_0000);
    reg_rw(3'd2, 32'h0000_1000, d);
    check("rw_same_cycle_old", d, 32'hAAAA_0000);
    reg_read(3'd2, d);
    check("rw_same_cycle_new", d, 32'h0000_1000);

    // basic dot product
    basic_data();
    setup_run(32'h1000, 32'h2000, 32'h0, 3, 2'b00);
    reg_write(3'd0, 32'h1);
    finish_run("basic", 200);
    reg_read(3'd5, d);
    check("basic_literal", d, 32'h0002_0000);

    // ReLU clamps a negative sum; write-back of clamped and raw values
    wv[0] = 32'hFFFF_0000;
    av[0] = 32'h0005_0000;
    setup_run(32'h1000, 32'h2000, 32'h3000, 1, 2'b11);
    reg_write(3'd0, 32'h1);
    finish_run("relu_wb", 200);
    setup_run(32'h1000, 32'h2000, 32'h3000, 1, 2'b10);
    reg_write(3'd0, 32'h1);
    finish_run("wb_raw", 200);
    reg_read(3'd5, d);
    check("wb_raw_literal", d, 32'hFFFB_0000);

    // LEN = 0 with write-back
    setup_run(32'h1000, 32'h2000, 32'h3000, 0, 2'b10);
    reg_write(3'd0, 32'h1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      reg_read(3'd0, d);
      if (d[0]) cnt++;
    end
    check("len0_busy_le3", cnt <= 3, 1'b1);
    check("len0_busy_seen", cnt >= 1, 1'b1);
    finish_run("len0", 50);

    // address wrap with no stalls
    for (int i = 0; i < 3; i++) begin
      wv[i] = $urandom;
      av[i] = $urandom;
    end
    setup_run(32'hFFFF_FFF8, 32'h7000, 32'h0, 3, 2'b00);
    reg_write(3'd0, 32'h1);
    finish_run("addr_wrap", 200);

    // stalls, random read latency, spurious valids
    stall_n = 5;
    dly_min = 0;
    dly_max = 6;
    spur_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        wv[i] = $urandom;
        av[i] = $urandom;
      end
      setup_run(32'h4000, 32'h5000, 32'h6000, 6, {1'b1, 1'(r)});
      reg_write(3'd0, 32'h1);
      finish_run($sformatf("stall%0d", r), 600);
    end
    spur_en = 1'b0;

    // busy protection
    basic_data();
    wv[3] = 32'h0003_0000;
    av[3] = 32'h0001_0000;
    reg_read(3'd5, prev_res);
    stall_n = 2;
    dly_min = 2;
    dly_max = 2;
    setup_run(32'h8000, 32'h9000, 32'h0, 4, 2'b00);
    reg_write(3'd0, 32'h1);
    reg_write(3'd4, 32'd9);
    reg_write(3'd2, 32'h0);
    reg_write(3'd0, 32'h1);
    reg_read(3'd5, d);
    check("busy_result_held", d, prev_res);
    finish_run("busy_prot", 300);
    reg_read(3'd4, d);
    check("busy_len_kept", d, 32'd4);
    reg_read(3'd2, d);
    check("busy_waddr_kept", d, 32'h8000);
    repeat (20) @(posedge clk);
    #1;
    check("busy_single_run", obs_q.size() - obs_rd, 0);

    // reset while a read request is stalled
    stall_n = 5;
    dly_min = 1;
    dly_max = 1;
    setup_run(32'h1000, 32'h2000, 32'h0, 3, 2'b00);
    reg_write(3'd0, 32'h1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (master_read === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("rd_stall_seen", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_rd_drop_read", master_read, 1'b0);
    check("rst_rd_drop_addr", master_address, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_q.size();

    // nonzero RESULT, then reset while waiting for activation data
    basic_data();
    stall_n = 0;
    setup_run(32'h1000, 32'h2000, 32'h0, 3, 2'b00);
    reg_write(3'd0, 32'h1);
    finish_run("pre_reset", 200);
    wv[3] = 32'h0001_0000;
    av[3] = 32'h0001_0000;
    dly_min = 5;
    dly_max = 5;
    setup_run(32'h1000, 32'h2000, 32'h0, 4, 2'b10);
    reg_write(3'd0, 32'h1);
    for (int c = 0; c < 60 && obs_q.size() < obs_rd + 2; c++) begin
      @(posedge clk);
      #1;
    end
    check("wt_a_reached", obs_q.size() >= obs_rd + 2, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_wta_read", master_read, 1'b0);
    check("rst_wta_write", master_write, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_q.size();
    for (int k = 0; k < 8; k++) begin
      reg_read(3'(k), d);
      check($sformatf("post_rst_reg%0d", k), d, 32'h0);
    end
    stray_req++;
    repeat (4) @(posedge clk);
    #1;
    reg_read(3'd0, d);
    check("stray_busy", d, 32'h0);
    reg_read(3'd5, d);
    check("stray_result", d, 32'h0);
    check("stray_no_xfer", obs_q.size() - obs_rd, 0);
    check("stray_master_read", master_read, 1'b0);

    // normal run after reset
    dly_min = 0;
    dly_max = 3;
    basic_data();
    setup_run(32'h1000, 32'h2000, 32'h3000, 3, 2'b10);
    reg_write(3'd0, 32'h1);
    finish_run("after_reset", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
